dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter WORD_IDX_BITS, default 8, meaning the number of word-index bits driven on AWADDR/ARADDR; upper bits are zero.
REQ-002 SHALL have ports:
  CLK  in  1  clock; all state changes on the rising edge
  RST  in  1  asynchronous, active-high reset
  REQ  in  1  core access request, sampled only in IDLE
  WE  in  1  1=store, 0=load
  FUNCT3  in  3  RV32I width/sign code
  ADDR  in  32  byte address
  WDATA_IN  in  32  store data, right-aligned
  BUSY  out  1  high in every state except IDLE
  DONE  out  1  one-cycle completion pulse
  ERR  out  1  valid with DONE; access rejected
  RDATA_OUT  out  32  load result, valid with DONE and held until the next DONE
  AWVALID  out  1  memory word write strobe
  AWADDR  out  32  memory word index
  WDATA  out  32  merged word to memory
  ARADDR  out  32  memory word index for read
  RDATA  in  32  combinational memory read word
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, RD, WR, RESP, with transitions as follows:
  IDLE->RD on REQ.
  RD->WR for a valid store.
  RD->RESP for a load or a rejected access.
  WR->RESP.
  RESP->IDLE.
REQ-005 On REQ in IDLE, ADDR, WE, FUNCT3 and WDATA_IN SHALL be latched; later input changes SHALL have no effect.
REQ-006 ARADDR and AWADDR SHALL both equal the latched ADDR[WORD_IDX_BITS+1:2], zero-extended.
REQ-007 In RD, RDATA SHALL be registered into an internal word register.
REQ-008 Loads SHALL select a byte or halfword from the registered word using latched ADDR[1:0], little-endian.
REQ-009 Load extension SHALL be:
  LB (000) and LH (001): sign-extend.
  LBU (100) and LHU (101): zero-extend.
  LW (010): whole word.
REQ-010 Stores SHALL merge into the registered word, replacing only the addressed bytes:
  SB (000): WDATA_IN[7:0].
  SH (001): WDATA_IN[15:0].
  SW (010): all four bytes.
REQ-011 AWVALID SHALL be high exactly one cycle, in WR only, with WDATA equal to the merged word; AWVALID SHALL be low at all other times.
REQ-012 FUNCT3 values 011, 110 and 111, and load codes 100/101 used with WE=1, SHALL set ERR, suppress the write and leave RDATA_OUT unchanged.
REQ-013 Latency SHALL be:
  Load: REQ accepted at edge N; DONE high in the cycle after edge N+1.
  Store: memory written at edge N+2; DONE in the cycle after edge N+2.
REQ-014 REQ SHALL be ignored while BUSY; back-to-back accesses SHALL be accepted the cycle DONE falls.
REQ-015 DONE and ERR SHALL be asserted only in RESP.

Reset
REQ-016 On RST, the block SHALL immediately, independent of CLK:
  enter IDLE.
  drive BUSY=0, DONE=0, ERR=0, AWVALID=0.
  set RDATA_OUT, AWADDR, ARADDR, WDATA and all internal registers to 0.
REQ-017 RST during RD or WR SHALL abort the access with no memory write and no DONE.

Configuration
REQ-018 With DMEM_LSU_MISALIGN_EN defined, each of the following SHALL complete with ERR=1, no write and RDATA_OUT unchanged:
  Halfword access with ADDR[0]=1.
  Word access with ADDR[1:0]!=0.
REQ-019 Without DMEM_LSU_MISALIGN_EN, misalignment SHALL NOT raise ERR; the block SHALL force natural alignment by clearing ADDR[0] for halfwords and ADDR[1:0] for words.

Verification
REQ-020 Word 3 preloaded 0x8899AABB; LB at ADDR=0x0E -> DONE 2 cycles after REQ, RDATA_OUT=0xFFFFFF99, ERR=0.
REQ-021 Same word; LHU at ADDR=0x0C -> RDATA_OUT=0x0000AABB.
REQ-022 Word 3=0x8899AABB; SB at ADDR=0x0D with WDATA_IN=0x123456CC -> one AWVALID pulse, AWADDR=3, WDATA=0x8899CCBB; DONE 3 cycles after REQ.
REQ-023 SW at ADDR=0x0E, with and without DMEM_LSU_MISALIGN_EN:
  With the macro: ERR=1, AWVALID never high.
  Without the macro: word 3 written with WDATA_IN.
REQ-024 RST pulsed during WR of an SW to word 5 -> AWVALID drops immediately; word 5 is unchanged; no DONE; BUSY=0.
REQ-025 FUNCT3=111 load -> ERR=1 with DONE; RDATA_OUT retains its previous value; REQ asserted while BUSY is ignored.

Source files
------------

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: one core access at a time against a word-wide memory
// with combinational read. Define DMEM_LSU_MISALIGN_EN to reject misaligned accesses.
module dmem_lsu #(
  parameter int WORD_IDX_BITS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA_OUT,
  output logic        AWVALID,
  output logic [31:0] AWADDR,
  output logic [31:0] WDATA,
  output logic [31:0] ARADDR,
  input  logic [31:0] RDATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                   state_q;
  logic                     we_q;
  logic [2:0]               funct3_q;
  logic [WORD_IDX_BITS+1:0] addr_q;
  logic [31:0]              wdata_in_q;
  logic [31:0]              word_q;
  logic [31:0]              rdata_out_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;
  logic                     awvalid_q;

  logic                     acc_err;
  logic [1:0]               lane;
  logic [31:0]              shifted;
  logic [31:0]              load_val;
  logic [31:0]              st_mask;
  logic [31:0]              st_data;
  logic [31:0]              merged;

  // Illegal codes and loads-only widths used for stores are always rejected.
  always_comb begin
    acc_err = 1'b0;
    case (funct3_q)
      3'b000, 3'b001, 3'b010: acc_err = 1'b0;
      3'b100, 3'b101:         acc_err = we_q;
      default:                acc_err = 1'b1;
    endcase
`ifdef DMEM_LSU_MISALIGN_EN
    if ((funct3_q[1:0] == 2'b01) && addr_q[0])
      acc_err = 1'b1;
    if ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00))
      acc_err = 1'b1;
`endif
  end

  // Natural alignment is forced; with the misalign check enabled the forced
  // cases are already errors, so the same lane logic serves both builds.
  always_comb begin
    lane = addr_q[1:0];
    if (funct3_q[1:0] == 2'b01)
      lane[0] = 1'b0;
    else if (funct3_q[1:0] == 2'b10)
      lane = 2'b00;
  end

  always_comb begin
    shifted  = word_q >> {lane, 3'b000};
    load_val = word_q;
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = word_q;
    endcase
  end

  always_comb begin
    st_mask = 32'hFFFF_FFFF;
    st_data = wdata_in_q;
    case (funct3_q[1:0])
      2'b00: begin
        st_mask = 32'h0000_00FF << {lane, 3'b000};
        st_data = {4{wdata_in_q[7:0]}};
      end
      2'b01: begin
        st_mask = 32'h0000_FFFF << {lane, 3'b000};
        st_data = {2{wdata_in_q[15:0]}};
      end
      default: begin
        st_mask = 32'hFFFF_FFFF;
        st_data = wdata_in_q;
      end
    endcase
    merged = (word_q & ~st_mask) | (st_data & st_mask);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_in_q  <= 32'd0;
      word_q      <= 32'd0;
      rdata_out_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      awvalid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ) begin
            we_q       <= WE;
            funct3_q   <= FUNCT3;
            addr_q     <= ADDR[WORD_IDX_BITS+1:0];
            wdata_in_q <= WDATA_IN;
            busy_q     <= 1'b1;
            state_q    <= RD;
          end
        end
        RD: begin
          word_q <= RDATA;
          if (acc_err) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= RESP;
          end else if (we_q) begin
            awvalid_q <= 1'b1;
            state_q   <= WR;
          end else begin
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= RESP;
          end
        end
        WR: begin
          awvalid_q <= 1'b0;
          err_q     <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          // The load result shown combinationally during RESP is held from here on.
          if (!we_q && !err_q)
            rdata_out_q <= load_val;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign AWVALID   = awvalid_q;
  assign ARADDR    = 32'(addr_q[WORD_IDX_BITS+1:2]);
  assign AWADDR    = 32'(addr_q[WORD_IDX_BITS+1:2]);
  assign WDATA     = merged;
  assign RDATA_OUT = ((state_q == RESP) && !we_q && !err_q) ? load_val : rdata_out_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: a 256-word memory model, directed accesses,
// and a scoreboard queue of expected completions.
module tb_dmem_lsu;

  logic        CLK;
  logic        RST;
  logic        REQ;
  logic        WE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR;
  logic [31:0] WDATA_IN;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [31:0] RDATA_OUT;
  logic        AWVALID;
  logic [31:0] AWADDR;
  logic [31:0] WDATA;
  logic [31:0] ARADDR;
  logic [31:0] RDATA;

  logic [31:0] mem [256];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          writes;
    logic [31:0] awaddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbQ[$];
  int   testCount = 0;
  int   failCount = 0;

  dmem_lsu #(.WORD_IDX_BITS(8)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .FUNCT3(FUNCT3), .ADDR(ADDR),
    .WDATA_IN(WDATA_IN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .RDATA_OUT(RDATA_OUT), .AWVALID(AWVALID), .AWADDR(AWADDR), .WDATA(WDATA),
    .ARADDR(ARADDR), .RDATA(RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: combinational read, write on the rising edge while AWVALID.
  assign RDATA = mem[ARADDR[7:0]];
  always @(posedge CLK) begin
    if (AWVALID)
      mem[AWADDR[7:0]] <= WDATA;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag, input logic gotDone, input int cyc,
                             input int nWrites, input logic [31:0] seenAw,
                             input logic [31:0] seenWd);
    exp_t e;
    e = sbQ.pop_front();
    check({tag, ".done"}, 32'(gotDone), 32'd1);
    check({tag, ".lat"}, 32'(cyc), 32'(e.lat));
    check({tag, ".err"}, 32'(ERR), 32'(e.err));
    check({tag, ".rdata"}, RDATA_OUT, e.rdata);
    check({tag, ".writes"}, 32'(nWrites), 32'(e.writes));
    if (e.writes > 0) begin
      check({tag, ".awaddr"}, seenAw, e.awaddr);
      check({tag, ".wdata"}, seenWd, e.wdata);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input exp_t e, input logic poke);
    int          cyc;
    int          nWrites;
    logic        gotDone;
    logic [31:0] seenAw;
    logic [31:0] seenWd;
    @(negedge CLK);
    REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = addr; WDATA_IN = wdata;
    sbQ.push_back(e);
    cyc = 0; nWrites = 0; gotDone = 1'b0; seenAw = 32'd0; seenWd = 32'd0;
    while (!gotDone && cyc < 10) begin
      @(negedge CLK);
      cyc++;
      REQ = poke; WE = ~we; FUNCT3 = 3'b110; ADDR = ~addr; WDATA_IN = ~wdata;
      if (AWVALID) begin
        nWrites++;
        seenAw = AWADDR;
        seenWd = WDATA;
      end
      if (DONE)
        gotDone = 1'b1;
    end
    REQ = 1'b0;
    checkOutput(tag, gotDone, cyc, nWrites, seenAw, seenWd);
  endtask

  function automatic exp_t mk(input logic err, input logic [31:0] rdata, input int lat,
                              input int writes, input logic [31:0] awaddr,
                              input logic [31:0] wdata);
    exp_t e;
    e.err = err; e.rdata = rdata; e.lat = lat;
    e.writes = writes; e.awaddr = awaddr; e.wdata = wdata;
    return e;
  endfunction

  initial begin
    logic [31:0] prevRd;
    logic [31:0] expMem3;
    logic        sawDone;

    for (int i = 0; i < 256; i++)
      mem[i] = 32'h0;
    mem[3] = 32'h8899AABB;
    mem[5] = 32'h11112222;
    mem[7] = 32'hCAFEF00D;
    RST = 1'b1; REQ = 1'b0; WE = 1'b0; FUNCT3 = 3'b000; ADDR = 32'd0; WDATA_IN = 32'd0;

    @(negedge CLK);
    check("rst.busy", 32'(BUSY), 32'd0);
    check("rst.done", 32'(DONE), 32'd0);
    check("rst.err", 32'(ERR), 32'd0);
    check("rst.awvalid", 32'(AWVALID), 32'd0);
    check("rst.rdata", RDATA_OUT, 32'd0);
    check("rst.araddr", ARADDR, 32'd0);
    check("rst.awaddr", AWADDR, 32'd0);
    check("rst.wdata", WDATA, 32'd0);
    RST = 1'b0;

    applyStimulus("lb0e", 1'b0, 3'b000, 32'h0E, 32'h0, mk(1'b0, 32'hFFFFFF99, 2, 0, 0, 0), 1'b0);
    applyStimulus("lhu0c", 1'b0, 3'b101, 32'h0C, 32'h0, mk(1'b0, 32'h0000AABB, 2, 0, 0, 0), 1'b0);
    applyStimulus("lh0e", 1'b0, 3'b001, 32'h0E, 32'h0, mk(1'b0, 32'hFFFF8899, 2, 0, 0, 0), 1'b0);
    applyStimulus("lbu0f", 1'b0, 3'b100, 32'h0F, 32'h0, mk(1'b0, 32'h00000088, 2, 0, 0, 0), 1'b0);
    applyStimulus("lw0c", 1'b0, 3'b010, 32'h0C, 32'h0, mk(1'b0, 32'h8899AABB, 2, 0, 0, 0), 1'b0);
`ifdef DMEM_LSU_MISALIGN_EN
    prevRd = 32'h8899AABB;
    applyStimulus("lh0d", 1'b0, 3'b001, 32'h0D, 32'h0, mk(1'b1, prevRd, 2, 0, 0, 0), 1'b0);
`else
    prevRd = 32'hFFFFAABB;
    applyStimulus("lh0d", 1'b0, 3'b001, 32'h0D, 32'h0, mk(1'b0, prevRd, 2, 0, 0, 0), 1'b0);
`endif

    // Illegal code with REQ held high while busy; must complete and return idle.
    applyStimulus("ld111", 1'b0, 3'b111, 32'h0C, 32'h0, mk(1'b1, prevRd, 2, 0, 0, 0), 1'b1);
    @(negedge CLK);
    check("ld111.idleBusy", 32'(BUSY), 32'd0);
    check("ld111.idleDone", 32'(DONE), 32'd0);

    applyStimulus("sb0d", 1'b1, 3'b000, 32'h0D, 32'h123456CC,
                  mk(1'b0, prevRd, 3, 1, 32'd3, 32'h8899CCBB), 1'b0);
    check("sb0d.mem3", mem[3], 32'h8899CCBB);
    applyStimulus("sh1e", 1'b1, 3'b001, 32'h1E, 32'h0000BEEF,
                  mk(1'b0, prevRd, 3, 1, 32'd7, 32'hBEEFF00D), 1'b0);
    check("sh1e.mem7", mem[7], 32'hBEEFF00D);
`ifdef DMEM_LSU_MISALIGN_EN
    expMem3 = 32'h8899CCBB;
    applyStimulus("sw0e", 1'b1, 3'b010, 32'h0E, 32'hA5A55A5A, mk(1'b1, prevRd, 2, 0, 0, 0), 1'b0);
`else
    expMem3 = 32'hA5A55A5A;
    applyStimulus("sw0e", 1'b1, 3'b010, 32'h0E, 32'hA5A55A5A,
                  mk(1'b0, prevRd, 3, 1, 32'd3, 32'hA5A55A5A), 1'b0);
`endif
    check("sw0e.mem3", mem[3], expMem3);
    applyStimulus("st100", 1'b1, 3'b100, 32'h0C, 32'h77777777, mk(1'b1, prevRd, 2, 0, 0, 0), 1'b0);
    check("st100.mem3", mem[3], expMem3);
    applyStimulus("lw1c", 1'b0, 3'b010, 32'h1C, 32'h0, mk(1'b0, 32'hBEEFF00D, 2, 0, 0, 0), 1'b0);

    // Reset asserted while the store to word 5 sits in WR.
    @(negedge CLK);
    REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h14; WDATA_IN = 32'hDEADBEEF;
    @(negedge CLK);
    REQ = 1'b0;
    @(negedge CLK);
    check("rstWr.awBefore", 32'(AWVALID), 32'd1);
    #1 RST = 1'b1;
    #1;
    check("rstWr.aw", 32'(AWVALID), 32'd0);
    check("rstWr.busy", 32'(BUSY), 32'd0);
    check("rstWr.done", 32'(DONE), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      sawDone = sawDone | DONE;
    end
    check("rstWr.noDone", 32'(sawDone), 32'd0);
    check("rstWr.mem5", mem[5], 32'h11112222);
    check("rstWr.rdata", RDATA_OUT, 32'd0);

    applyStimulus("lb14", 1'b0, 3'b000, 32'h14, 32'h0, mk(1'b0, 32'h00000022, 2, 0, 0, 0), 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
